// File: rtl/sram_pkg.sv
// Shared types and constants for the sram_bank store.
package sram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int nbytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return delay line: valid/err shift every cycle, data only moves with valid
// so the output word holds its last value between reads.
module sram_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  input  logic              i_err,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic              o_err,
  output logic [DATA_W-1:0] o_data
);

  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_err;
  logic [DATA_W-1:0] r_data [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < RD_LAT; i++) r_data[i] <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_err[0] <= i_err;
      if (i_vld) r_data[0] <= i_data;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        if (r_vld[i-1]) r_data[i] <= r_data[i-1];
      end
    end
  end

  assign o_vld  = r_vld[RD_LAT-1];
  assign o_err  = r_err[RD_LAT-1];
  assign o_data = r_data[RD_LAT-1];

endmodule

// File: rtl/sram_bank.sv
// Single-port synchronous SRAM bank with byte enables, zero-fill engine,
// registered read return and out-of-range error pulse.
//   state    | meaning
//   ST_IDLE  | Ready=1, accesses accepted
//   ST_CLEAR | writing 0 to r_cnt each cycle, accesses dropped
module sram_bank
  import sram_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        Cs_b,
  input  logic                        We_b,
  input  logic [ADDR_W-1:0]           Address,
  input  logic [DATA_W-1:0]           Wdata,
  input  logic [nbytes(DATA_W)-1:0]   Be_b,
  input  logic                        Clear_req,
  output logic [DATA_W-1:0]           Rdata,
  output logic                        Rvalid,
  output logic                        Ready,
  output logic                        Err
);

  localparam int NB  = nbytes(DATA_W);
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              w_clr_we;
  logic              w_oor, w_acc, w_rd_acc, w_wr_acc;
  logic              r_wr_err, w_pipe_err;
  logic [DATA_W-1:0] w_rd_data;

  assign Ready    = (r_state == ST_IDLE);
  assign w_oor    = (32'(Address) >= 32'(DEPTH));
  // Clear_req wins over a same-cycle access; rst_n gating keeps the array frozen in reset.
  assign w_acc    = rst_n && !Cs_b && Ready && !Clear_req;
  assign w_rd_acc = w_acc && We_b;
  assign w_wr_acc = w_acc && !We_b && !w_oor;
  assign w_rd_data = w_oor ? '0 : r_mem[Address];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      r_cnt    <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wr_err <= w_acc && !We_b && w_oor;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        w_clr_we = rst_n;
        if (r_cnt == LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (!Be_b[b]) r_mem[Address][8*b +: 8] <= Wdata[8*b +: 8];
      end
    end
  end

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (LAT)
  ) u_rd_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (w_rd_acc),
    .i_err  (w_rd_acc && w_oor),
    .i_data (w_rd_data),
    .o_vld  (Rvalid),
    .o_err  (w_pipe_err),
    .o_data (Rdata)
  );

  assign Err = w_pipe_err | r_wr_err;

endmodule

// File: tb/tb_sram_bank.sv
// Two banks (256 deep / latency 1, 200 deep / latency 2) share one stimulus
// stream and are each checked every cycle against a schedule-based model.
module tb_sram_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Cs_b = 1'b1, We_b = 1'b1, Clear_req = 1'b0;
  logic [7:0]  Address = '0;
  logic [15:0] Wdata = '0;
  logic [1:0]  Be_b = 2'b11;

  logic [15:0] a_rdata, b_rdata;
  logic        a_rvalid, b_rvalid, a_ready, b_ready, a_err, b_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_bank #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .rst_n(rst_n), .Cs_b(Cs_b), .We_b(We_b), .Address(Address), .Wdata(Wdata),
    .Be_b(Be_b), .Clear_req(Clear_req), .Rdata(a_rdata), .Rvalid(a_rvalid), .Ready(a_ready),
    .Err(a_err));

  sram_bank #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .rst_n(rst_n), .Cs_b(Cs_b), .We_b(We_b), .Address(Address), .Wdata(Wdata),
    .Be_b(Be_b), .Clear_req(Clear_req), .Rdata(b_rdata), .Rvalid(b_rvalid), .Ready(b_ready),
    .Err(b_err));

  function automatic int dep(input int k);
    return (k == 0) ? 256 : 200;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per bank, remaining busy cycles, word array, and a small ring of
  // output events keyed by the edge after which they must be visible.
  logic [15:0] m_mem [2][256];
  int          m_busy [2];
  logic        m_sv [2][4];
  logic        m_se [2][4];
  logic [15:0] m_sd [2][4];
  logic [15:0] e_rdata [2];
  logic        e_rvalid [2];
  logic        e_err [2];
  int          cyc = 0;
  logic        m_acc, m_oor;
  int          m_s;

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 256; j++) m_mem[k][j] = '0;
      m_busy[k] = 0;
      e_rdata[k] = '0; e_rvalid[k] = 1'b0; e_err[k] = 1'b0;
      for (int s = 0; s < 4; s++) begin m_sv[k][s] = 1'b0; m_se[k][s] = 1'b0; m_sd[k][s] = '0; end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = dep(k);
        e_rdata[k] = '0; e_rvalid[k] = 1'b0; e_err[k] = 1'b0;
        for (int s = 0; s < 4; s++) begin m_sv[k][s] = 1'b0; m_se[k][s] = 1'b0; end
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        m_acc = (m_busy[k] == 0) && !Cs_b && !Clear_req;
        m_oor = (int'(Address) >= dep(k));
        if (m_busy[k] > 0) m_busy[k]--;
        else if (Clear_req) begin
          m_busy[k] = dep(k);
          for (int j = 0; j < 256; j++) m_mem[k][j] = '0;
        end
        if (m_acc && We_b) begin
          m_s = (cyc + lat(k) - 1) % 4;
          m_sv[k][m_s] = 1'b1;
          m_sd[k][m_s] = m_oor ? 16'h0 : m_mem[k][Address];
          m_se[k][m_s] = m_se[k][m_s] | m_oor;
        end else if (m_acc && m_oor) begin
          m_se[k][cyc % 4] = 1'b1;
        end else if (m_acc) begin
          for (int b = 0; b < 2; b++)
            if (!Be_b[b]) m_mem[k][Address][8*b +: 8] = Wdata[8*b +: 8];
        end
        m_s = cyc % 4;
        e_rvalid[k] = m_sv[k][m_s];
        e_err[k]    = m_se[k][m_s];
        if (m_sv[k][m_s]) e_rdata[k] = m_sd[k][m_s];
        m_sv[k][m_s] = 1'b0;
        m_se[k][m_s] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("a_rvalid", 32'(a_rvalid), 32'(e_rvalid[0]));
    chk("a_err",    32'(a_err),    32'(e_err[0]));
    chk("a_ready",  32'(a_ready),  32'(m_busy[0] == 0));
    chk("a_rdata",  32'(a_rdata),  32'(e_rdata[0]));
    chk("b_rvalid", 32'(b_rvalid), 32'(e_rvalid[1]));
    chk("b_err",    32'(b_err),    32'(e_err[1]));
    chk("b_ready",  32'(b_ready),  32'(m_busy[1] == 0));
    chk("b_rdata",  32'(b_rdata),  32'(e_rdata[1]));
  end

  task automatic drive(input logic cs, input logic we, input logic [7:0] a,
                       input logic [15:0] d, input logic [1:0] be, input logic clr);
    Cs_b = cs; We_b = we; Address = a; Wdata = d; Be_b = be; Clear_req = clr;
    @(negedge clk);
    Cs_b = 1'b1; Clear_req = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    drive(1'b0, 1'b0, a, d, be, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a);
    drive(1'b0, 1'b1, a, 16'h0, 2'b11, 1'b0);
  endtask

  // One read; records data, err and the cycle count to the first Rvalid of each bank.
  task automatic read_cap(input logic [7:0] a, output logic [15:0] da, output logic [15:0] db,
                          output int la, output int lb, output logic ea, output logic eb);
    la = 0; lb = 0; da = '0; db = '0; ea = 1'b0; eb = 1'b0;
    Cs_b = 1'b0; We_b = 1'b1; Address = a; Clear_req = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      Cs_b = 1'b1;
      if (a_rvalid && la == 0) begin la = i; da = a_rdata; ea = a_err; end
      if (b_rvalid && lb == 0) begin lb = i; db = b_rdata; eb = b_err; end
    end
  endtask

  task automatic count_ready(input int pulse_at, output int ca, output int cb);
    #1;
    ca = 0; cb = 0;
    for (int i = 0; i < 400; i++) begin
      if (!a_ready) ca++;
      if (!b_ready) cb++;
      @(negedge clk);
      Clear_req = (i == pulse_at);
    end
    Clear_req = 1'b0;
  endtask

  task automatic check_read(input string nm, input logic [7:0] a,
                            input logic [15:0] xa, input logic [15:0] xb);
    logic [15:0] da, db;
    int la, lb;
    logic ea, eb;
    read_cap(a, da, db, la, lb, ea, eb);
    chk({nm, "_data_a"}, 32'(da), 32'(xa));
    chk({nm, "_data_b"}, 32'(db), 32'(xb));
    chk({nm, "_lat_a"}, 32'(la), 32'd1);
    chk({nm, "_lat_b"}, 32'(lb), 32'd2);
  endtask

  task automatic reset_checks();
    chk("rst_rvalid_a", 32'(a_rvalid), 32'd0);
    chk("rst_rvalid_b", 32'(b_rvalid), 32'd0);
    chk("rst_rdata_a",  32'(a_rdata),  32'd0);
    chk("rst_rdata_b",  32'(b_rdata),  32'd0);
    chk("rst_ready_a",  32'(a_ready),  32'd0);
    chk("rst_ready_b",  32'(b_ready),  32'd0);
    chk("rst_err_a",    32'(a_err),    32'd0);
    chk("rst_err_b",    32'(b_err),    32'd0);
  endtask

  initial begin
    int ca, cb, la, lb;
    logic [15:0] da, db;
    logic ea, eb;

    #2 rst_n = 1'b0;
    #1 reset_checks();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_ready(-1, ca, cb);
    chk("init_clear_cycles_a", 32'(ca), 32'd256);
    chk("init_clear_cycles_b", 32'(cb), 32'd200);
    check_read("rd_a5", 8'hA5, 16'h0000, 16'h0000);

    wr(8'h10, 16'hBEEF, 2'b00);
    wr(8'h10, 16'h1234, 2'b10);
    check_read("byte_en", 8'h10, 16'hBE34, 16'hBE34);

    wr(8'h01, 16'h0011, 2'b00); wr(8'h02, 16'h0022, 2'b00);
    wr(8'h03, 16'h0033, 2'b00); wr(8'h04, 16'h0044, 2'b00);
    rd(8'h01); rd(8'h02); rd(8'h03); rd(8'h04);
    repeat (3) @(negedge clk);

    // Read then same-address write on the next cycle: read keeps old data.
    da = '0; db = '0;
    Cs_b = 1'b0; We_b = 1'b1; Address = 8'h01;
    @(negedge clk);
    if (a_rvalid) da = a_rdata;
    We_b = 1'b0; Wdata = 16'hFFFF; Be_b = 2'b00;
    @(negedge clk);
    Cs_b = 1'b1;
    if (b_rvalid) db = b_rdata;
    chk("raw_hazard_a", 32'(da), 32'h0011);
    chk("raw_hazard_b", 32'(db), 32'h0011);
    check_read("after_wr", 8'h01, 16'hFFFF, 16'hFFFF);

    wr(8'h08, 16'h5A5A, 2'b00);
    Cs_b = 1'b0; We_b = 1'b0; Address = 8'hC8; Wdata = 16'h1111; Be_b = 2'b00;
    @(negedge clk);
    Cs_b = 1'b1;
    chk("oor_wr_err_a", 32'(a_err), 32'd0);
    chk("oor_wr_err_b", 32'(b_err), 32'd1);
    read_cap(8'hC8, da, db, la, lb, ea, eb);
    chk("oor_rd_data_a", 32'(da), 32'h1111);
    chk("oor_rd_data_b", 32'(db), 32'h0000);
    chk("oor_rd_err_a", 32'(ea), 32'd0);
    chk("oor_rd_err_b", 32'(eb), 32'd1);
    chk("oor_rd_lat_b", 32'(lb), 32'd2);
    check_read("alias_08", 8'h08, 16'h5A5A, 16'h5A5A);

    // Clear with a same-cycle out-of-range write (must not raise Err), then a mid-clear request.
    drive(1'b0, 1'b0, 8'hC8, 16'hAAAA, 2'b00, 1'b1);
    count_ready(100, ca, cb);
    chk("clr_cycles_a", 32'(ca), 32'd256);
    chk("clr_cycles_b", 32'(cb), 32'd200);
    check_read("after_clr", 8'h10, 16'h0000, 16'h0000);

    for (int i = 0; i < 3000; i++) begin
      Cs_b      = ($urandom_range(0, 3) == 0);
      We_b      = 1'($urandom_range(0, 1));
      Address   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(190, 255));
      Wdata     = 16'($urandom);
      Be_b      = 2'($urandom);
      Clear_req = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    Cs_b = 1'b1; Clear_req = 1'b0;
    repeat (300) @(negedge clk);

    // Reset with reads in flight: outputs drop immediately, no Rvalid afterwards.
    Cs_b = 1'b0; We_b = 1'b1; Address = 8'h03;
    @(negedge clk);
    Address = 8'h04;
    @(posedge clk);
    #2 rst_n = 1'b0;
    Cs_b = 1'b1;
    #1 reset_checks();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_ready(-1, ca, cb);
    chk("rst_clear_cycles_a", 32'(ca), 32'd256);
    chk("rst_clear_cycles_b", 32'(cb), 32'd200);

    // Reset during a clear restarts it from address 0.
    drive(1'b1, 1'b1, 8'h00, 16'h0, 2'b11, 1'b1);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_ready(-1, ca, cb);
    chk("abort_clear_cycles_a", 32'(ca), 32'd256);
    chk("abort_clear_cycles_b", 32'(cb), 32'd200);
    check_read("final", 8'hA5, 16'h0000, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bank.md
Name: sram_bank

Overview:
- Parametrised, synchronous, single-port SRAM bank. It replaces the asynchronous active-low-strobe SRAM as the weight and activation store for the fixed-point MAC datapath.
- Adds a clock and configurable width, depth and read latency.
- Adds active-low byte enables, a hardware clear engine with a busy/ready indication, a registered read-valid handshake, and an out-of-range error flag.

Parameters:
- DATA_W, 16: data word width in bits; must be a multiple of 8.
- ADDR_W, 8: address width in bits.
- DEPTH, 256: number of words; 1 <= DEPTH <= 2**ADDR_W.
- RD_LAT, 1: read latency in clock cycles, from the accepting edge to Rvalid; legal values are 1 and 2.
- CLEAR_ON_RESET, 1: when 1, the bank zero-fills itself after reset release.

Ports:
- clk  input  1  system clock; all state is updated on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Cs_b  input  1  active-low chip select / access request.
- We_b  input  1  active-low write enable; 1 = read, 0 = write.
- Address  input  ADDR_W  word address.
- Wdata  input  DATA_W  write data.
- Be_b  input  DATA_W/8  active-low byte enables; bit i covers Wdata[8i+7:8i].
- Clear_req  input  1  one-cycle pulse that starts a zero-fill of the whole bank.
- Rdata  output  DATA_W  read data; valid while Rvalid=1, otherwise holds its last value.
- Rvalid  output  1  one-cycle pulse per accepted read.
- Ready  output  1  1 = accesses are accepted; 0 = clear in progress.
- Err  output  1  one-cycle pulse for an accepted access with Address >= DEPTH.

Behaviour:
- Reset values (rst_n=0, asynchronous): Rdata=0, Rvalid=0, Err=0, read pipeline flushed, clear counter=0.
  - Ready=0 if CLEAR_ON_RESET=1, else Ready=1.
  - Memory contents are not reset by rst_n.
- State machine with two states, IDLE and CLEAR.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - CLEAR: writes 0 to address cnt each cycle, cnt runs 0..DEPTH-1. The cycle that writes DEPTH-1 moves to IDLE. The clear takes exactly DEPTH cycles; Ready goes to 1 on the following cycle.
  - IDLE -> CLEAR on Clear_req=1. The clear counter restarts at 0 and Ready=0 from the next cycle.
  - Clear_req in CLEAR is ignored; the clear is not restarted.
- Accept rule: an access is accepted at a rising edge when Cs_b=0 and Ready=1. Accesses presented while Ready=0 are dropped silently: no write, no Rvalid, no Err.
- Clear_req has priority over an access presented in the same cycle: the access is dropped.
- Write (accepted, We_b=0):
  - For each i with Be_b[i]=0, mem[Address] byte i <= Wdata byte i; other bytes are unchanged.
  - Be_b all ones means no change, and the write is still counted as accepted.
- Read (accepted, We_b=1):
  - Array data is sampled at the accepting edge.
  - Rdata/Rvalid appear RD_LAT cycles later: RD_LAT=1 gives them after the next edge; RD_LAT=2 adds one output register.
  - Back-to-back reads on consecutive cycles give back-to-back Rvalid pulses with full throughput.
  - A write to the same address in the cycle after a read does not affect that read's data.
- Out of range (accepted, Address >= DEPTH; only possible when DEPTH < 2**ADDR_W):
  - Writes are discarded.
  - Reads return Rdata=0 with Rvalid=1.
  - Err pulses in the same cycle Rvalid would for a read, and 1 cycle after acceptance for a write.
- Reset asserted mid-operation:
  - In-flight reads are lost; no Rvalid is produced for them.
  - A clear in progress is aborted and restarts from address 0 after release if CLEAR_ON_RESET=1.
- Reads accepted just before a Clear_req still complete with their pre-clear data.

Decomposition:
- Package sram_pkg:
  - state enum {ST_IDLE, ST_CLEAR};
  - constants RD_LAT_MIN=1 and RD_LAT_MAX=2;
  - function nbytes(DATA_W) = DATA_W/8.
- Sub-module sram_rd_pipe: a parametrised RD_LAT-stage valid/data/err delay line with asynchronous active-low reset.
- sram_bank holds the array, byte-enable write logic, the clear FSM and counter, and the accept/range decode.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, DEPTH=256 -> Ready=0 for exactly 256 cycles, then 1; a read of address 0xA5 returns 0x0000.
- Write 0xBEEF to 0x10 with Be_b=00, then write 0x1234 with Be_b=10 -> a read of 0x10 returns 0xBE34, with Rvalid exactly RD_LAT cycles after acceptance, for RD_LAT=1 and RD_LAT=2.
- Four consecutive reads of addresses 1..4 preloaded with 0x0011..0x0044 -> four consecutive Rvalid pulses in address order; read of 1, write 0xFFFF to 1 next cycle -> first read still 0x0011.
- DEPTH=200, write to 0xC8 then read 0xC8 -> Err pulses for both accesses, Rdata=0 with Rvalid=1 on the read, and address 0x08 unchanged.
- Clear_req in IDLE with Cs_b=0/We_b=0 in the same cycle -> write dropped; Ready low for DEPTH cycles; a second Clear_req at mid-clear ignored, so the total is still DEPTH cycles.
- rst_n pulsed low with two reads in flight (RD_LAT=2) -> no Rvalid; outputs return to reset values immediately, without waiting for a clock edge.
